// File: rtl/norm_lzc_pipe.sv
// Two-stage leading-zero counter and normaliser with exponent-limited (gradual underflow) shift.
// Latency: an operand captured on one edge is presented on the outputs after the next edge.
// Backpressure: each stage holds one entry; in_ready = !s1_vld | s1_adv, combinational from out_ready only.
module norm_lzc_pipe #(
    parameter  int MANT_W  = 24,
    parameter  int EXP_W   = 8,
    parameter  int GROUP_W = 4,
    localparam int SH_W    = $clog2(MANT_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic [SH_W-1:0]   out_shift,
    output logic              out_zero,
    output logic              out_denorm
);

    localparam int NG = MANT_W / GROUP_W;
    localparam int LW = $clog2(GROUP_W + 1);
    localparam int CW = (EXP_W > SH_W) ? EXP_W : SH_W;

    logic s1_vld;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_vld || s2_adv;
    assign in_ready = s1_adv;

    // Group zero flags and local counts; index 0 is the most significant group.
    logic [NG-1:0]          zf_c;
    logic [NG-1:0][LW-1:0]  loc_c;
    logic [GROUP_W-1:0]     grp;

    always_comb begin
        zf_c  = '0;
        loc_c = '0;
        grp   = '0;
        for (int g = 0; g < NG; g++) begin
            grp      = in_mant[MANT_W-1-g*GROUP_W -: GROUP_W];
            zf_c[g]  = ~|grp;
            loc_c[g] = LW'(GROUP_W);
            for (int b = 0; b < GROUP_W; b++) begin
                if (grp[b]) loc_c[g] = LW'(GROUP_W - 1 - b);
            end
        end
    end

    logic [MANT_W-1:0]      s1_mant;
    logic [EXP_W-1:0]       s1_exp;
    logic [NG-1:0]          s1_zf;
    logic [NG-1:0][LW-1:0]  s1_loc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_mant <= '0;
            s1_exp  <= '0;
            s1_zf   <= '0;
            s1_loc  <= '0;
        end else if (s1_adv) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_mant <= in_mant;
                s1_exp  <= in_exp;
                s1_zf   <= zf_c;
                s1_loc  <= loc_c;
            end
        end
    end

    logic [SH_W-1:0] lzc;
    logic            found;

    always_comb begin
        lzc   = SH_W'(MANT_W);
        found = 1'b0;
        for (int g = 0; g < NG; g++) begin
            if (!found && !s1_zf[g]) begin
                lzc   = SH_W'(g * GROUP_W) + SH_W'(s1_loc[g]);
                found = 1'b1;
            end
        end
    end

    logic [CW-1:0]     lzc_x;
    logic [CW-1:0]     exp_x;
    logic [SH_W-1:0]   sh_c;
    logic [EXP_W-1:0]  exp_c;
    logic [MANT_W-1:0] mant_c;
    logic              zero_c;
    logic              dn_c;

    assign lzc_x = CW'(lzc);
    assign exp_x = CW'(s1_exp);

    // A zero mantissa shifted by MANT_W stays zero, so one shifter serves every case.
    always_comb begin
        sh_c   = '0;
        exp_c  = '0;
        zero_c = 1'b0;
        dn_c   = 1'b0;
        if (!found) begin
            sh_c   = SH_W'(MANT_W);
            zero_c = 1'b1;
        end else if (lzc_x < exp_x) begin
            sh_c  = lzc;
            exp_c = s1_exp - EXP_W'(lzc_x);
        end else if (s1_exp != '0) begin
            sh_c = SH_W'(exp_x - CW'(1));
            dn_c = 1'b1;
        end else begin
            dn_c = 1'b1;
        end
        mant_c = s1_mant << sh_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_mant   <= '0;
            out_exp    <= '0;
            out_shift  <= '0;
            out_zero   <= 1'b0;
            out_denorm <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_mant   <= mant_c;
                out_exp    <= exp_c;
                out_shift  <= sh_c;
                out_zero   <= zero_c;
                out_denorm <= dn_c;
            end
        end
    end

endmodule

// File: tb/tb_norm_lzc_pipe.sv
// Bench for norm_lzc_pipe: directed vectors, backpressure, mid-stream reset and a randomized
// sweep over four geometries checked against an arithmetic reference model.
module tb_norm_lzc_pipe;

    typedef struct packed {
        logic [63:0] mant;
        logic [15:0] exp;
        logic [7:0]  sh;
        logic        z;
        logic        dn;
    } res_t;
    typedef res_t [3:0] res4_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [23:0] m24;
    logic [7:0]  e8;
    logic [52:0] m53;
    logic [10:0] e11;

    logic [3:0]  irdy;
    logic [3:0]  ovld;
    logic [23:0] om [3];
    logic [7:0]  oe [3];
    logic [4:0]  os [3];
    logic        oz [3];
    logic        od [3];
    logic [52:0] om3;
    logic [10:0] oe3;
    logic [5:0]  os3;
    logic        oz3;
    logic        od3;

    res4_t       obs4;
    res4_t       sbq [$];
    logic [24:0] cov24;
    logic [53:0] cov53;
    int          checks;
    int          errors;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g24
        norm_lzc_pipe #(.MANT_W(24), .EXP_W(8), .GROUP_W(k == 0 ? 4 : (k == 1 ? 1 : 8))) u (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[k]),
            .in_mant(m24), .in_exp(e8), .out_valid(ovld[k]), .out_ready(out_ready),
            .out_mant(om[k]), .out_exp(oe[k]), .out_shift(os[k]), .out_zero(oz[k]),
            .out_denorm(od[k])
        );
    end

    norm_lzc_pipe #(.MANT_W(53), .EXP_W(11), .GROUP_W(1)) u53 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[3]),
        .in_mant(m53), .in_exp(e11), .out_valid(ovld[3]), .out_ready(out_ready),
        .out_mant(om3), .out_exp(oe3), .out_shift(os3), .out_zero(oz3), .out_denorm(od3)
    );

    function automatic res_t mk(logic [63:0] m, logic [15:0] e, logic [7:0] s, logic z, logic d);
        res_t r;
        r.mant = m; r.exp = e; r.sh = s; r.z = z; r.dn = d;
        return r;
    endfunction

    always_comb begin
        obs4 = {mk(64'(om3), 16'(oe3), 8'(os3), oz3, od3),
                mk(64'(om[2]), 16'(oe[2]), 8'(os[2]), oz[2], od[2]),
                mk(64'(om[1]), 16'(oe[1]), 8'(os[1]), oz[1], od[1]),
                mk(64'(om[0]), 16'(oe[0]), 8'(os[0]), oz[0], od[0])};
    end

    // Reference: count zeros from the top, then apply the normalisation rules with integers.
    function automatic res_t ref_model(logic [63:0] m, int e, int mw);
        res_t        r;
        int          lzc;
        logic [63:0] mask;
        r    = '0;
        mask = (64'd1 << mw) - 64'd1;
        lzc  = mw;
        for (int i = 0; i < mw; i++) if (m[i]) lzc = mw - 1 - i;
        if (lzc == mw) begin
            r.z  = 1'b1;
            r.sh = 8'(mw);
        end else if (lzc < e) begin
            r.sh   = 8'(lzc);
            r.exp  = 16'(e - lzc);
            r.mant = (m << lzc) & mask;
        end else if (e >= 1) begin
            r.sh   = 8'(e - 1);
            r.mant = (m << (e - 1)) & mask;
            r.dn   = 1'b1;
        end else begin
            r.mant = m;
            r.dn   = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [63:0] mk_mant(int lz, int mw);
        logic [63:0] r;
        logic [63:0] one;
        r = {$urandom, $urandom};
        if (lz >= mw) return 64'd0;
        one = 64'd1 << (mw - 1 - lz);
        return (r & (one - 64'd1)) | one;
    endfunction

    task automatic gen_op(input int idx, output res4_t r);
        int          l24, l53, x24, x53;
        logic [63:0] a, b;
        l24 = idx % 25;
        l53 = idx % 54;
        a   = mk_mant(l24, 24);
        b   = mk_mant(l53, 53);
        case ($urandom_range(0, 3))
            0:       x24 = l24;
            1:       x24 = l24 + 1;
            2:       x24 = $urandom_range(0, 255);
            default: x24 = $urandom_range(0, 30);
        endcase
        case ($urandom_range(0, 3))
            0:       x53 = l53;
            1:       x53 = l53 + 1;
            2:       x53 = $urandom_range(0, 2047);
            default: x53 = $urandom_range(0, 60);
        endcase
        m24 = a[23:0];
        e8  = 8'(x24);
        m53 = b[52:0];
        e11 = 11'(x53);
        cov24[l24] = 1'b1;
        cov53[l53] = 1'b1;
        r[0] = ref_model(a, x24, 24);
        r[1] = r[0];
        r[2] = r[0];
        r[3] = ref_model(b, x53, 53);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        m24 = '0; e8 = '0; m53 = '0; e11 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ovld !== 4'b0 || obs4 !== '0 || irdy !== 4'hf) begin
            errors++;
            $display("FAIL reset_state vld=%b rdy=%b outs=%h required vld=0 rdy=f outs=0", ovld, irdy, obs4);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (irdy !== 4'hf) begin
            errors++;
            $display("FAIL reset_release_ready got=%b required=1111", irdy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input string name, input logic [23:0] m, input logic [7:0] e, input res_t want);
        m24 = m; e8 = e; m53 = '0; e11 = '0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ovld[0] !== 1'b0) begin
            errors++;
            $display("FAIL %s_early_valid got=%b required=0", name, ovld[0]);
        end
        @(negedge clk);
        checks++;
        if (ovld[0] !== 1'b1 || obs4[0] !== want) begin
            errors++;
            $display("FAIL %s vld=%b got=%h required vld=1 %h", name, ovld[0], obs4[0], want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        send_one("norm_none",  24'h800000, 8'd127, mk(64'h800000, 16'd127, 8'd0, 1'b0, 1'b0));
        send_one("norm_full",  24'h000001, 8'd127, mk(64'h800000, 16'd104, 8'd23, 1'b0, 1'b0));
        send_one("limit_e5",   24'h000100, 8'd5,   mk(64'h001000, 16'd0, 8'd4, 1'b0, 1'b1));
        send_one("exp_zero",   24'h000100, 8'd0,   mk(64'h000100, 16'd0, 8'd0, 1'b0, 1'b1));
        send_one("mant_zero",  24'h000000, 8'd90,  mk(64'h0, 16'd0, 8'd24, 1'b1, 1'b0));
        send_one("lzc_lt_exp", 24'h000100, 8'd16,  mk(64'h800000, 16'd1, 8'd15, 1'b0, 1'b0));
        send_one("lzc_eq_exp", 24'h000100, 8'd15,  mk(64'h400000, 16'd0, 8'd14, 1'b0, 1'b1));
    endtask

    // mode 0: random valid/ready; mode 1: back-to-back with out_ready low in cycles 3..6;
    // mode 2: back-to-back at full rate.
    task automatic run_stream(input string name, input int n_ops, input int mode);
        res4_t cur, held, front;
        bit    hold_prev, saw_low, acc, exp_rdy;
        int    sent, popped, cyc;
        sent = 0; popped = 0; cyc = 0; hold_prev = 1'b0; saw_low = 1'b0; held = '0;
        sbq.delete();
        while (!(sent == n_ops && sbq.size() == 0) && cyc < n_ops * 8 + 40) begin
            if (!in_valid && sent < n_ops && (mode != 0 || $urandom_range(0, 3) != 0)) begin
                gen_op(sent, cur);
                in_valid = 1'b1;
            end
            out_ready = (mode == 1) ? !(cyc >= 3 && cyc <= 6) :
                        (mode == 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            exp_rdy = (sbq.size() < 2) || out_ready;
            checks++;
            if (irdy !== {4{exp_rdy}} || ovld !== {4{ovld[0]}}) begin
                errors++;
                $display("FAIL %s_in_ready cyc=%0d got=%b vld=%b required=%b", name, cyc, irdy, ovld, exp_rdy);
            end
            if (hold_prev) begin
                checks++;
                if (ovld[0] !== 1'b1 || obs4 !== held) begin
                    errors++;
                    $display("FAIL %s_hold cyc=%0d vld=%b got=%h required=%h", name, cyc, ovld[0], obs4, held);
                end
            end
            if (ovld[0] === 1'b1 && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL %s_spurious cyc=%0d got=%h required=no result", name, cyc, obs4);
                end else begin
                    front = sbq.pop_front();
                    popped++;
                    if (obs4 !== front) begin
                        errors++;
                        $display("FAIL %s_data cyc=%0d got=%h required=%h", name, cyc, obs4, front);
                    end
                end
            end
            hold_prev = (ovld[0] === 1'b1) && !out_ready;
            held      = obs4;
            if (!irdy[0] && !out_ready) saw_low = 1'b1;
            acc = in_valid && irdy[0];
            if (acc) begin
                sbq.push_back(cur);
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (sent != n_ops || sbq.size() != 0) begin
            errors++;
            $display("FAIL %s_drain sent=%0d pending=%0d required sent=%0d pending=0", name, sent, sbq.size(), n_ops);
        end
        if (mode == 1) begin
            checks++;
            if (!saw_low || popped != n_ops) begin
                errors++;
                $display("FAIL %s_stall saw_low=%0d popped=%0d required 1 and %0d", name, saw_low, popped, n_ops);
            end
        end
        if (mode == 2) begin
            checks++;
            if (cyc != n_ops + 2) begin
                errors++;
                $display("FAIL %s_throughput cycles=%0d required=%0d", name, cyc, n_ops + 2);
            end
        end
    endtask

    task automatic test_backpressure();
        run_stream("backpressure", 6, 1);
    endtask

    task automatic test_back_to_back();
        run_stream("back_to_back", 40, 2);
    endtask

    task automatic test_sweep();
        cov24 = '0;
        cov53 = '0;
        run_stream("sweep", 600, 0);
        checks++;
        if (cov24 !== '1 || cov53 !== '1) begin
            errors++;
            $display("FAIL sweep_lzc_coverage got=%h/%h required all ones", cov24, cov53);
        end
    endtask

    task automatic test_mid_reset();
        res4_t dummy;
        out_ready = 1'b0;
        gen_op(3, dummy);
        in_valid = 1'b1;
        @(posedge clk);
        #1 gen_op(7, dummy);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ovld !== 4'hf || irdy !== 4'h0) begin
            errors++;
            $display("FAIL midreset_full vld=%b rdy=%b required vld=1111 rdy=0000", ovld, irdy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ovld !== 4'h0 || obs4 !== '0 || irdy !== 4'hf) begin
            errors++;
            $display("FAIL midreset_clear vld=%b rdy=%b outs=%h required vld=0 rdy=f outs=0", ovld, irdy, obs4);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (irdy !== 4'hf || ovld !== 4'h0) begin
            errors++;
            $display("FAIL midreset_release rdy=%b vld=%b required rdy=1111 vld=0000", irdy, ovld);
        end
        @(posedge clk);
        #1;
        send_one("after_reset", 24'h000030, 8'd200, mk(64'hC00000, 16'd182, 8'd18, 1'b0, 1'b0));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_sweep();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
